// File: rtl/cmpxchg_wb_seq.sv
// CMPXCHG writeback sequencer: turns the execute-stage compare result into
// register-file and locked memory writes, then retires the instruction.
module cmpxchg_wb_seq #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned EAX_IDX     = 0,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             ex_zf,
  input  logic             ex_dest_mem,
  input  logic [2:0]       ex_dest_reg,
  input  logic [WIDTH-1:0] ex_dest_val,
  input  logic [WIDTH-1:0] ex_src_val,
  input  logic [31:0]      ex_addr,
  output logic             reg_we,
  output logic [2:0]       reg_waddr,
  output logic [WIDTH-1:0] reg_wdata,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  output logic             lock,
  output logic             flags_we,
  output logic             zf_out,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, MEMWR, REGWR, DONE} state_t;

  localparam logic [2:0] EAX     = 3'(EAX_IDX);
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t           state;
  logic             zf_q;
  logic [WIDTH-1:0] dest_val_q;
  logic [7:0]       ack_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ex_ready   <= 1'b1;
      reg_we     <= 1'b0;
      reg_waddr  <= '0;
      reg_wdata  <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      lock       <= 1'b0;
      flags_we   <= 1'b0;
      zf_out     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      zf_q       <= 1'b0;
      dest_val_q <= '0;
      ack_cnt    <= '0;
    end else begin
      reg_we   <= 1'b0;
      flags_we <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            ex_ready   <= 1'b0;
            zf_q       <= ex_zf;
            dest_val_q <= ex_dest_val;
            if (ex_dest_mem) begin
              state     <= MEMWR;
              mem_req   <= 1'b1;
              lock      <= 1'b1;
              mem_addr  <= ex_addr;
              mem_wdata <= ex_zf ? ex_src_val : ex_dest_val;
              ack_cnt   <= '0;
            end else begin
              state     <= REGWR;
              reg_we    <= 1'b1;
              reg_waddr <= ex_zf ? ex_dest_reg : EAX;
              reg_wdata <= ex_zf ? ex_src_val : ex_dest_val;
            end
          end
        end
        MEMWR: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (zf_q) begin
              state    <= DONE;
              lock     <= 1'b0;
              flags_we <= 1'b1;
              zf_out   <= zf_q;
              done     <= 1'b1;
            end else begin
              // lock stays up through the EAX write so the RMW stays atomic
              state     <= REGWR;
              reg_we    <= 1'b1;
              reg_waddr <= EAX;
              reg_wdata <= dest_val_q;
            end
          end else if (ack_cnt == TO_LAST) begin
            state    <= DONE;
            err      <= 1'b1;
            mem_req  <= 1'b0;
            lock     <= 1'b0;
            flags_we <= 1'b1;
            zf_out   <= zf_q;
            done     <= 1'b1;
          end else begin
            ack_cnt <= ack_cnt + 8'd1;
          end
        end
        REGWR: begin
          state    <= DONE;
          lock     <= 1'b0;
          flags_we <= 1'b1;
          zf_out   <= zf_q;
          done     <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          ex_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmpxchg_wb_seq.sv
// Directed bench for cmpxchg_wb_seq: register/memory destinations, success and
// failure, ack wait, ack timeout and mid-operation reset.
module tb_cmpxchg_wb_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_zf;
  logic        ex_dest_mem;
  logic [2:0]  ex_dest_reg;
  logic [31:0] ex_dest_val;
  logic [31:0] ex_src_val;
  logic [31:0] ex_addr;
  logic        reg_we;
  logic [2:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        lock;
  logic        flags_we;
  logic        zf_out;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  cmpxchg_wb_seq #(.WIDTH(32), .EAX_IDX(0), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_zf(ex_zf),
    .ex_dest_mem(ex_dest_mem), .ex_dest_reg(ex_dest_reg),
    .ex_dest_val(ex_dest_val), .ex_src_val(ex_src_val), .ex_addr(ex_addr),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .lock(lock), .flags_we(flags_we), .zf_out(zf_out),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic zf, input logic mem, input logic [2:0] dreg,
                       input logic [31:0] dval, input logic [31:0] sval,
                       input logic [31:0] addr);
    ex_zf = zf; ex_dest_mem = mem; ex_dest_reg = dreg;
    ex_dest_val = dval; ex_src_val = sval; ex_addr = addr;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_zf = 1'b0; ex_dest_mem = 1'b0;
    ex_dest_reg = '0; ex_dest_val = '0; ex_src_val = '0; ex_addr = '0;
    mem_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_ready", ex_ready, 1);
    check("rst_outs", {reg_we, mem_req, lock, flags_we, done, err}, 6'b0);
    check("rst_data", {reg_waddr, reg_wdata, mem_addr, mem_wdata}, '0);

    // reg dest, success
    issue(1'b1, 1'b0, 3'd3, 32'h0000_1111, 32'hDEAD_BEEF, 32'h0);
    check("r1_we", reg_we, 1);
    check("r1_waddr", reg_waddr, 3);
    check("r1_wdata", reg_wdata, 32'hDEAD_BEEF);
    check("r1_busy", {ex_ready, mem_req, lock, done}, 4'b0);
    tick();
    check("r1_done", {done, flags_we, zf_out, reg_we, mem_req}, 5'b11100);
    tick();
    check("r1_idle", {ex_ready, done, flags_we}, 3'b100);

    // reg dest, failure -> EAX gets old DEST
    issue(1'b0, 1'b0, 3'd5, 32'h1234_5678, 32'h9999_0000, 32'h0);
    check("r0_we", {reg_we, reg_waddr, lock}, {1'b1, 3'd0, 1'b0});
    check("r0_wdata", reg_wdata, 32'h1234_5678);
    tick();
    check("r0_done", {done, flags_we, zf_out, lock}, 4'b1100);
    tick();

    // mem dest, success, ack in 4th MEMWR cycle
    issue(1'b1, 1'b1, 3'd2, 32'h77, 32'h55, 32'h1000);
    for (int i = 0; i < 3; i++) begin
      check("m1_hold", {mem_req, lock, reg_we, done}, 4'b1100);
      tick();
    end
    check("m1_addr", mem_addr, 32'h1000);
    check("m1_wdata", mem_wdata, 32'h55);
    mem_ack = 1'b1;
    check("m1_hold4", {mem_req, lock}, 2'b11);
    tick();
    mem_ack = 1'b0;
    check("m1_done", {done, flags_we, zf_out, mem_req, lock, reg_we, err}, 7'b1110000);
    tick();
    check("m1_idle", {ex_ready, done}, 2'b10);

    // mem dest, failure, immediate ack -> memory rewritten, then EAX
    issue(1'b0, 1'b1, 3'd6, 32'hAA, 32'h33, 32'h2000);
    mem_ack = 1'b1;
    check("m0_mem", {mem_req, lock, mem_wdata}, {2'b11, 32'hAA});
    tick();
    mem_ack = 1'b0;
    check("m0_reg", {reg_we, reg_waddr, reg_wdata, mem_req, lock, done},
          {1'b1, 3'd0, 32'hAA, 1'b0, 1'b1, 1'b0});
    tick();
    check("m0_done", {done, flags_we, zf_out, lock, reg_we}, 5'b11000);
    tick();

    // stray ack while idle has no effect
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("idle_ack", {ex_ready, mem_req, reg_we, done}, 4'b1000);

    // timeout: 4 MEMWR cycles without ack
    issue(1'b1, 1'b1, 3'd1, 32'h1, 32'h2, 32'h3000);
    for (int i = 0; i < 4; i++) begin
      check("to_hold", {mem_req, lock, err, done}, 4'b1100);
      tick();
    end
    check("to_done", {err, done, flags_we, mem_req, lock, reg_we}, 6'b111000);
    tick();
    check("to_sticky", {err, ex_ready, reg_we}, 3'b110);
    issue(1'b1, 1'b0, 3'd4, 32'h0, 32'h44, 32'h0);
    check("to_sticky2", {err, reg_we, reg_waddr}, {2'b11, 3'd4});
    tick(); tick();

    // reset during MEMWR drops the op
    issue(1'b1, 1'b1, 3'd0, 32'h5, 32'h6, 32'h4000);
    check("rm_memwr", {mem_req, lock}, 2'b11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rm_after", {ex_ready, mem_req, lock, done, flags_we, err}, 6'b100000);
    tick();
    check("rm_nodone", {done, ex_ready}, 2'b01);

    // back-to-back ops after reset
    issue(1'b1, 1'b0, 3'd7, 32'h0, 32'hCAFE_F00D, 32'h0);
    check("bb1_we", {reg_we, reg_waddr, reg_wdata}, {1'b1, 3'd7, 32'hCAFE_F00D});
    tick();
    check("bb1_done", {done, zf_out}, 2'b11);
    tick();
    issue(1'b0, 1'b0, 3'd2, 32'h0BAD_0BAD, 32'h1, 32'h0);
    check("bb2_we", {reg_we, reg_waddr, reg_wdata}, {1'b1, 3'd0, 32'h0BAD_0BAD});
    tick();
    check("bb2_done", {done, zf_out, err}, 3'b100);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
